next_piece_ctrl: RTL and testbench

//  Sequencer for the next-piece preview path. Generates the Tetris piece stream

---
 rtl/tetris_pkg.sv | 28 ++
 rtl/lfsr16.sv | 22 ++
 rtl/next_piece_ctrl.sv | 129 ++++++++++++
 tb/tb_next_piece_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared piece encoding and preview image geometry for the Tetris display path.
package tetris_pkg;

  localparam int unsigned PIECE_W = 3;

  localparam logic [PIECE_W-1:0] PIECE_I = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_O = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_T = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_S = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_Z = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_J = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_L = 3'd6;

  localparam int unsigned PREVIEW_W  = 100;
  localparam int unsigned PREVIEW_H  = 78;
  localparam int unsigned IMG_PIXELS = PREVIEW_W * PREVIEW_H;

  // Index of the lowest set bit of a bag mask; the mask is never empty in use.
  function automatic logic [PIECE_W-1:0] lowest_set(input logic [6:0] mask);
    logic [PIECE_W-1:0] idx;
    idx = PIECE_I;
    for (int i = 6; i >= 0; i--) begin
      if (mask[i]) idx = PIECE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (poly 16'hB400), free-running, reloads the seed on reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  localparam logic [15:0] POLY = 16'hB400;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (q[0]) begin
      q <= (q >> 1) ^ POLY;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/next_piece_ctrl.sv
// Next-piece sequencer: 7-bag draw from an LFSR, req/valid hand-off to game logic,
// and a preview ROM base that only moves on frame_start so the preview never tears.
module next_piece_ctrl
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned IMG_PIXELS = tetris_pkg::PREVIEW_W * tetris_pkg::PREVIEW_H,
  parameter int unsigned ROM_ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  piece_req,
  output logic                  ready,
  output logic                  piece_valid,
  output logic [PIECE_W-1:0]    piece_id,
  output logic [PIECE_W-1:0]    next_id,
  output logic [ROM_ADDR_W-1:0] preview_base
);

  localparam logic [0:0] S_DRAW = 1'b0;
  localparam logic [0:0] S_IDLE = 1'b1;

  logic [15:0]           lfsr;
  logic                  unused_lfsr_hi;

  logic [0:0]            state_q, state_d;
  logic [6:0]            bag_mask_q, bag_mask_d;
  logic [2:0]            try_cnt_q, try_cnt_d;
  logic [PIECE_W-1:0]    next_id_q, next_id_d;
  logic [PIECE_W-1:0]    piece_id_q, piece_id_d;
  logic                  piece_valid_q, piece_valid_d;
  logic [ROM_ADDR_W-1:0] preview_q, preview_d;

  logic [PIECE_W-1:0]    cand;
  logic [7:0]            mask_ext;
  logic                  hit;
  logic                  commit;
  logic [PIECE_W-1:0]    commit_id;
  logic [6:0]            cleared;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Only the low bits pick a candidate; the rest just keep the sequence long.
  assign unused_lfsr_hi = ^lfsr[15:3];

  assign cand     = lfsr[2:0];
  // Bit 7 is tied low so candidate 7 is always a miss.
  assign mask_ext = {1'b0, bag_mask_q};
  assign hit      = mask_ext[cand];

  always_comb begin
    state_d       = state_q;
    bag_mask_d    = bag_mask_q;
    try_cnt_d     = try_cnt_q;
    next_id_d     = next_id_q;
    piece_id_d    = piece_id_q;
    piece_valid_d = 1'b0;
    commit        = 1'b0;
    commit_id     = cand;
    cleared       = bag_mask_q;

    case (state_q)
      S_DRAW: begin
        if (hit) begin
          commit = 1'b1;
        end else if (try_cnt_q == 3'd7) begin
          // Eighth straight miss: fall back to the lowest remaining piece.
          commit    = 1'b1;
          commit_id = lowest_set(bag_mask_q);
        end else begin
          try_cnt_d = try_cnt_q + 3'd1;
        end
      end
      S_IDLE: begin
        if (piece_req) begin
          piece_valid_d = 1'b1;
          piece_id_d    = next_id_q;
          state_d       = S_DRAW;
        end
      end
      default: state_d = S_DRAW;
    endcase

    if (commit) begin
      next_id_d  = commit_id;
      try_cnt_d  = '0;
      state_d    = S_IDLE;
      cleared    = bag_mask_q & ~(7'b1 << commit_id);
      bag_mask_d = (cleared == '0) ? 7'h7F : cleared;
    end
  end

  // Uses the registered next_id, so a same-cycle draw shows on the next frame.
  assign preview_d = frame_start ? ROM_ADDR_W'(32'(next_id_q) * IMG_PIXELS) : preview_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_DRAW;
      bag_mask_q    <= 7'h7F;
      try_cnt_q     <= '0;
      next_id_q     <= '0;
      piece_id_q    <= '0;
      piece_valid_q <= 1'b0;
      preview_q     <= '0;
    end else begin
      state_q       <= state_d;
      bag_mask_q    <= bag_mask_d;
      try_cnt_q     <= try_cnt_d;
      next_id_q     <= next_id_d;
      piece_id_q    <= piece_id_d;
      piece_valid_q <= piece_valid_d;
      preview_q     <= preview_d;
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign piece_valid  = piece_valid_q;
  assign piece_id     = piece_id_q;
  assign next_id      = next_id_q;
  assign preview_base = preview_q;

endmodule

// File: tb/tb_next_piece_ctrl.sv
// Scoreboard bench for next_piece_ctrl: a bag/queue reference model predicts each draw
// and handshake; a negedge monitor compares outputs and pops expected pieces.
module tb_next_piece_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          IMG  = 7800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        piece_req = 1'b0;
  logic        ready;
  logic        piece_valid;
  logic [2:0]  piece_id;
  logic [2:0]  next_id;
  logic [15:0] preview_base;

  always #5 clk = ~clk;

  next_piece_ctrl #(
    .LFSR_SEED  (SEED),
    .IMG_PIXELS (IMG),
    .ROM_ADDR_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .piece_req    (piece_req),
    .ready        (ready),
    .piece_valid  (piece_valid),
    .piece_id     (piece_id),
    .next_id      (next_id),
    .preview_base (preview_base)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_bag[$];
  bit          m_ready, m_valid, m_rst_cycle, m_hs;
  bit          started = 1'b0;
  int          m_next, m_piece, m_preview, m_cnt, m_pend;
  int          sb[$];
  int          rec_a[$];
  int          rec_b[$];
  int          recording = 0;
  int          low_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic bit in_bag(input int id);
    foreach (m_bag[i]) if (m_bag[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bag_min();
    int m = 99;
    foreach (m_bag[i]) if (m_bag[i] < m) m = m_bag[i];
    return m;
  endfunction

  function automatic void bag_refill();
    m_bag = {0, 1, 2, 3, 4, 5, 6};
  endfunction

  function automatic void bag_take(input int id);
    foreach (m_bag[i]) begin
      if (m_bag[i] == id) begin
        m_bag.delete(i);
        break;
      end
    end
    if (m_bag.size() == 0) bag_refill();
  endfunction

  function automatic logic [6:0] bag_mask();
    logic [6:0] m = '0;
    foreach (m_bag[i]) m[m_bag[i]] = 1'b1;
    return m;
  endfunction

  // Whole draw predicted up front: first remaining id among 8 LFSR picks, else lowest.
  task automatic predict(input logic [15:0] l0);
    logic [15:0] l;
    l = l0;
    for (int t = 1; t <= 8; t++) begin
      int c;
      c = int'(l[2:0]);
      if (c < 7 && in_bag(c)) begin
        m_pend = c;
        m_cnt  = t;
        return;
      end
      if (t == 8) begin
        m_pend = bag_min();
        m_cnt  = 8;
        return;
      end
      l = lfsr_step(l);
    end
  endtask

  // Model: advances at each active edge from the inputs the bench is applying.
  initial forever begin
    @(posedge clk);
    started = 1'b1;
    if (rst) begin
      m_lfsr      = SEED;
      bag_refill();
      m_ready     = 1'b0;
      m_valid     = 1'b0;
      m_next      = 0;
      m_piece     = 0;
      m_preview   = 0;
      m_rst_cycle = 1'b1;
      predict(m_lfsr);
    end else begin
      m_rst_cycle = 1'b0;
      m_hs        = m_ready && piece_req;
      if (frame_start) m_preview = m_next * IMG;
      m_valid = m_hs;
      if (m_hs) begin
        m_piece = m_next;
        sb.push_back(m_next);
        m_ready = 1'b0;
      end else if (!m_ready) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_next  = m_pend;
          bag_take(m_pend);
          m_ready = 1'b1;
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
      if (m_hs) predict(m_lfsr);
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("ready", 32'(ready), 32'(m_ready));
      check("piece_valid", 32'(piece_valid), 32'(m_valid));
      check("piece_id_hold", 32'(piece_id), 32'(m_piece));
      check("next_id", 32'(next_id), 32'(m_next));
      check("preview_base", 32'(preview_base), 32'(m_preview));
      check("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
      check("bag_mask", 32'(dut.bag_mask_q), 32'(bag_mask()));
      if (piece_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_pop: piece_valid with id %0d, expected no piece (t=%0t)",
                   piece_id, $time);
        end else begin
          check("sb_piece", 32'(piece_id), 32'(sb.pop_front()));
        end
        if (recording == 1) rec_a.push_back(int'(piece_id));
        if (recording == 2) rec_b.push_back(int'(piece_id));
      end
      if (m_rst_cycle) begin
        low_run = 1;
      end else if (!ready) begin
        low_run++;
      end else if (low_run > 0) begin
        check("draw_latency_le8", 32'(low_run <= 8), 32'd1);
        low_run = 0;
      end
    end
  end

  initial begin
    int  cnt;
    bit  found;

    // Reset for 3 cycles, then hold req through the draws.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    recording = 1;
    rst       = 1'b0;
    piece_req = 1'b1;
    repeat (80) @(negedge clk);
    piece_req = 1'b0;
    recording = 0;

    check("perm_len", 32'(rec_a.size() >= 7), 32'd1);
    if (rec_a.size() >= 7) begin
      for (int id = 0; id < 7; id++) begin
        cnt = 0;
        for (int k = 0; k < 7; k++) if (rec_a[k] == id) cnt++;
        check("perm_count", 32'(cnt), 32'd1);
      end
    end

    // Random traffic with frame pulses.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      piece_req   = ($urandom_range(0, 2) == 0);
      frame_start = ($urandom_range(0, 4) == 0);
    end
    frame_start = 1'b0;

    // Wait for next_id 6, then pulse frame_start.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (m_next == 6) found = 1'b1;
      else piece_req = ($urandom_range(0, 1) == 0);
    end
    if (found) begin
      piece_req   = 1'b0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("preview_46800", 32'(preview_base), 32'd46800);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL next6_reach: got next_id %0d, expected 6 within 400 cycles", m_next);
    end

    // Reset while a draw is in progress.
    piece_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (!m_ready) found = 1'b1;
    end
    check("draw_seen_before_rst", 32'(found), 32'd1);
    rst       = 1'b1;
    piece_req = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_preview", 32'(preview_base), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr), 32'(SEED));
    @(negedge clk);
    recording = 2;
    rst       = 1'b0;
    piece_req = 1'b1;
    repeat (80) @(negedge clk);
    piece_req = 1'b0;
    recording = 0;

    check("replay_len", 32'(rec_b.size()), 32'(rec_a.size()));
    for (int k = 0; k < rec_a.size() && k < rec_b.size(); k++) begin
      check("replay_piece", 32'(rec_b[k]), 32'(rec_a[k]));
    end

    // Dense frame pulses so some coincide with draw commits.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      piece_req   = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 1) == 0);
    end
    piece_req   = 1'b0;
    frame_start = 1'b0;
    repeat (12) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
